// File: rtl/subtractor_serial.sv
// subtractor_serial: bit-serial A - B, LSB first, start/busy/done handshake.
// Rev 1.0
`default_nettype none

module subtractor_serial #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Diff_reg,
   output logic             Borrow_reg,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic             bin;
   logic [CW-1:0]    cnt;

   logic             bit_a;
   logic             bit_b;
   logic             bit_d;
   logic             bout;
   logic             last;
   logic [WIDTH-1:0] d_next;

   always_comb begin
      bit_a      = a_sh[0];
      bit_b      = b_sh[0];
      bit_d      = bit_a ^ bit_b ^ bin;
      bout       = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bin);
      d_next     = {bit_d, d_sh[WIDTH-1:1]};
      last       = (state == SHIFT) && (cnt == LAST_CNT);
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = SHIFT;
         SHIFT:   if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Busy is a decode of the state flop, so it is glitch-free and registered.
   assign Busy = (state == SHIFT);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         d_sh       <= '0;
         bin        <= 1'b0;
         cnt        <= '0;
         Diff_reg   <= '0;
         Borrow_reg <= 1'b0;
         Done       <= 1'b0;
      end else begin
         state <= state_next;
         Done  <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  a_sh <= A;
                  b_sh <= B;
                  bin  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               d_sh <= d_next;
               bin  <= bout;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  Diff_reg   <= d_next;
                  Borrow_reg <= bout;
                  Done       <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
